// File: rtl/multi_ip_comparator.sv
// Multi-pattern byte-stream comparator: matches NUM_PAT patterns at every byte offset across beat boundaries.
// Optional per-slot saturating hit counters are enabled by defining MCMP_HIT_CNT_EN.
module multi_ip_comparator #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned PAT_BYTES  = 4,
  parameter int unsigned NUM_PAT    = 4,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned DW    = 8 * DATA_BYTES,
  localparam int unsigned PW    = 8 * PAT_BYTES,
  localparam int unsigned IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int unsigned OFF_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               pat_load,
  input  logic [IDX_W-1:0]   pat_sel,
  input  logic [PW-1:0]      pat_in,
  input  logic               pat_en_in,
  input  logic               in_valid,
  input  logic [DW-1:0]      data_in,
  output logic               out_valid,
  output logic [DW-1:0]      data_out,
  output logic               match,
  output logic [NUM_PAT-1:0] match_vec,
  output logic [IDX_W-1:0]   match_idx,
  output logic [OFF_W-1:0]   match_off
`ifdef MCMP_HIT_CNT_EN
  ,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
`endif
);

  generate
    if (PAT_BYTES > DATA_BYTES || NUM_PAT < 1) begin : g_bad_cfg
      $error("multi_ip_comparator: need PAT_BYTES <= DATA_BYTES and NUM_PAT >= 1");
    end
  endgenerate

  logic [PW-1:0]         pat [NUM_PAT];
  logic [NUM_PAT-1:0]    pat_en;
  logic [DW-1:0]         prev;
  logic                  prev_valid;
  logic [2*DW-1:0]       win_c;
  logic [DATA_BYTES-1:0] hit_c [NUM_PAT];
  logic [NUM_PAT-1:0]    vec_c;
  logic [IDX_W-1:0]      idx_c;
  logic [OFF_W-1:0]      off_c;
  logic [DATA_BYTES-1:0] sel_hits_c;

  // Pattern bank; out-of-range slot indices are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PAT); i++) pat[i] <= '0;
      pat_en <= '0;
    end else if (pat_load && (32'(pat_sel) < NUM_PAT)) begin
      pat[pat_sel]    <= pat_in;
      pat_en[pat_sel] <= pat_en_in;
    end
  end

  assign win_c = {prev, data_in};

  // Byte offset o is counted from the MSB (first on the wire) byte of prev
  generate
    for (genvar i = 0; i < int'(NUM_PAT); i++) begin : g_pat
      for (genvar o = 0; o < int'(DATA_BYTES); o++) begin : g_off
        assign hit_c[i][o] = pat_en[i] && (win_c[2*DW-1-8*o -: PW] == pat[i]);
      end
      assign vec_c[i] = |hit_c[i];
    end
  endgenerate

  // Lowest slot wins, then lowest offset within that slot
  always_comb begin
    idx_c      = '0;
    off_c      = '0;
    sel_hits_c = '0;
    for (int i = int'(NUM_PAT) - 1; i >= 0; i--) begin
      if (vec_c[i]) begin
        idx_c      = IDX_W'(i);
        sel_hits_c = hit_c[i];
      end
    end
    for (int o = int'(DATA_BYTES) - 1; o >= 0; o--) begin
      if (sel_hits_c[o]) off_c = OFF_W'(o);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      match      <= 1'b0;
      match_vec  <= '0;
      match_idx  <= '0;
      match_off  <= '0;
    end else if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      match      <= 1'b0;
      match_vec  <= '0;
      match_idx  <= '0;
      match_off  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        prev       <= data_in;
        prev_valid <= 1'b1;
        if (prev_valid) begin
          out_valid <= 1'b1;
          data_out  <= prev;
          match     <= |vec_c;
          match_vec <= vec_c;
          match_idx <= idx_c;
          match_off <= off_c;
        end
      end
    end
  end

`ifdef MCMP_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PAT];

  // Saturating counters driven by the registered result; clear leaves them alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PAT); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_PAT); i++) begin
        if (out_valid && match_vec[i] && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  generate
    for (genvar i = 0; i < int'(NUM_PAT); i++) begin : g_cnt
      assign hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_multi_ip_comparator.sv
// Bench for multi_ip_comparator: byte-level reference model, directed cases and random traffic.
module tb_multi_ip_comparator;
  localparam int unsigned DB   = 4;
  localparam int unsigned PB   = 4;
  localparam int unsigned NP   = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned DW   = 8 * DB;
  localparam int unsigned PW   = 8 * PB;
  localparam int unsigned IW   = 2;
  localparam int unsigned OW   = 2;
  localparam int          MAXC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear, pat_load, pat_en_in, in_valid;
  logic [IW-1:0] pat_sel;
  logic [PW-1:0] pat_in;
  logic [DW-1:0] data_in;
  logic          out_valid, match;
  logic [DW-1:0] data_out;
  logic [NP-1:0] match_vec;
  logic [IW-1:0] match_idx;
  logic [OW-1:0] match_off;
`ifdef MCMP_HIT_CNT_EN
  logic [NP*CW-1:0] hit_cnt;
`endif

  multi_ip_comparator #(.DATA_BYTES(DB), .PAT_BYTES(PB), .NUM_PAT(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .pat_load(pat_load), .pat_sel(pat_sel),
    .pat_in(pat_in), .pat_en_in(pat_en_in), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .match(match), .match_vec(match_vec),
    .match_idx(match_idx), .match_off(match_off)
`ifdef MCMP_HIT_CNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] mpat [NP];
  logic [NP-1:0] men;
  logic [DW-1:0] mprev;
  logic          mpv;
  logic          e_valid;
  logic [DW-1:0] e_data;
  logic [NP-1:0] e_vec;
  logic [IW-1:0] e_idx;
  logic [OW-1:0] e_off;
  int            mcnt [NP];

  function automatic bit f_match(input logic [DW-1:0] p, input logic [DW-1:0] c, input int s, input int o);
    logic [2*DW-1:0] w;
    logic [PW-1:0]   pt;
    w  = {p, c};
    pt = mpat[s];
    if (!men[s]) return 1'b0;
    for (int k = 0; k < int'(PB); k++)
      if (w[2*DW-1-8*(o+k) -: 8] != pt[PW-1-8*k -: 8]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NP-1:0] f_vec(input logic [DW-1:0] p, input logic [DW-1:0] c);
    logic [NP-1:0] v = '0;
    for (int s = 0; s < int'(NP); s++)
      for (int o = 0; o < int'(DB); o++)
        if (f_match(p, c, s, o)) v[s] = 1'b1;
    return v;
  endfunction

  function automatic int f_idx(input logic [DW-1:0] p, input logic [DW-1:0] c);
    logic [NP-1:0] v = f_vec(p, c);
    for (int s = 0; s < int'(NP); s++) if (v[s]) return s;
    return 0;
  endfunction

  function automatic int f_off(input logic [DW-1:0] p, input logic [DW-1:0] c);
    logic [NP-1:0] v = f_vec(p, c);
    int s = f_idx(p, c);
    if (v == '0) return 0;
    for (int o = 0; o < int'(DB); o++) if (f_match(p, c, s, o)) return o;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NP); i++) begin mpat[i] <= '0; mcnt[i] <= 0; end
      men <= '0; mprev <= '0; mpv <= 1'b0;
      e_valid <= 1'b0; e_data <= '0; e_vec <= '0; e_idx <= '0; e_off <= '0;
    end else begin
      for (int i = 0; i < int'(NP); i++)
        if (e_valid && e_vec[i] && mcnt[i] < MAXC) mcnt[i] <= mcnt[i] + 1;
      if (clear) begin
        mpv <= 1'b0; mprev <= '0;
        e_valid <= 1'b0; e_data <= '0; e_vec <= '0; e_idx <= '0; e_off <= '0;
      end else begin
        e_valid <= 1'b0;
        if (in_valid) begin
          if (mpv) begin
            e_valid <= 1'b1;
            e_data  <= mprev;
            e_vec   <= f_vec(mprev, data_in);
            e_idx   <= IW'(f_idx(mprev, data_in));
            e_off   <= OW'(f_off(mprev, data_in));
          end
          mprev <= data_in;
          mpv   <= 1'b1;
        end
      end
      if (pat_load && int'(pat_sel) < int'(NP)) begin
        mpat[pat_sel] <= pat_in;
        men[pat_sel]  <= pat_en_in;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("data_out",  64'(data_out),  64'(e_data));
      chk("match",     64'(match),     64'(|e_vec));
      chk("match_vec", 64'(match_vec), 64'(e_vec));
      chk("match_idx", 64'(match_idx), 64'(e_idx));
      chk("match_off", 64'(match_off), 64'(e_off));
`ifdef MCMP_HIT_CNT_EN
      for (int i = 0; i < int'(NP); i++)
        chk("hit_cnt", 64'(hit_cnt[i*CW +: CW]), 64'(mcnt[i]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [DW-1:0] d, input logic clr);
    in_valid = v; data_in = d; clear = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic load(input int s, input logic [PW-1:0] p, input logic en);
    pat_load = 1'b1; pat_sel = IW'(s); pat_in = p; pat_en_in = en;
    step(1'b0, '0, 1'b0);
    pat_load = 1'b0;
  endtask

  task automatic lit(input string n, input logic ov, input logic [DW-1:0] d, input logic m,
                     input logic [NP-1:0] v, input int idx, input int off);
    chk({n, ".valid"}, 64'(out_valid), 64'(ov));
    chk({n, ".data"},  64'(data_out),  64'(d));
    chk({n, ".match"}, 64'(match),     64'(m));
    chk({n, ".vec"},   64'(match_vec), 64'(v));
    chk({n, ".idx"},   64'(match_idx), 64'(idx));
    chk({n, ".off"},   64'(match_off), 64'(off));
  endtask

  function automatic logic [7:0] rb();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'hC0;
      2: return 8'hA8;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [31:0] rword();
    return {rb(), rb(), rb(), rb()};
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0; pat_load = 1'b0; pat_sel = '0; pat_in = '0;
    pat_en_in = 1'b0; in_valid = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    lit("reset", 1'b0, 32'h0, 1'b0, 4'b0000, 0, 0);

    load(0, 32'hC0A80101, 1'b1);

    // Aligned match at offset 0
    step(1'b1, 32'hC0A80101, 1'b0);
    chk("first_beat_no_out", 64'(out_valid), 64'(0));
    step(1'b1, 32'h00000000, 1'b0);
    lit("aligned", 1'b1, 32'hC0A80101, 1'b1, 4'b0001, 0, 0);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.match", 64'(match), 64'(0));
    chk("rst.data",  64'(data_out), 64'(0));
    @(negedge clk); rst = 1'b0;
    load(0, 32'hC0A80101, 1'b1);
    step(1'b1, 32'hC0A80101, 1'b0);
    chk("post_rst_no_out", 64'(out_valid), 64'(0));
    step(1'b1, 32'h00000000, 1'b0);
    step(1'b0, '0, 1'b1);

    // Straddle across the word boundary
    step(1'b1, 32'h00C0A801, 1'b0);
    step(1'b1, 32'h01000000, 1'b0);
    lit("straddle1", 1'b1, 32'h00C0A801, 1'b1, 4'b0001, 0, 1);
    step(1'b1, 32'h00000000, 1'b0);
    lit("straddle2", 1'b1, 32'h01000000, 1'b0, 4'b0000, 0, 0);
    step(1'b0, '0, 1'b0);
    chk("hold.valid", 64'(out_valid), 64'(0));
    chk("hold.data",  64'(data_out), 64'(32'h01000000));
    step(1'b0, '0, 1'b1);

    // Two slots hit the same window; slot 2 starts two bytes in
    load(2, 32'hA8010100, 1'b1);
    step(1'b1, 32'h00C0A801, 1'b0);
    step(1'b1, 32'h01000000, 1'b0);
    lit("multi", 1'b1, 32'h00C0A801, 1'b1, 4'b0101, 0, 1);
    step(1'b0, '0, 1'b1);
    load(0, 32'hC0A80101, 1'b0);
    step(1'b1, 32'h00C0A801, 1'b0);
    step(1'b1, 32'h01000000, 1'b0);
    lit("slot2", 1'b1, 32'h00C0A801, 1'b1, 4'b0100, 2, 2);
    step(1'b0, '0, 1'b1);
    load(0, 32'hC0A80101, 1'b1);
    load(2, 32'h0, 1'b0);

    // clear beats in_valid, then history reloads without output
    step(1'b1, 32'hC0A80101, 1'b0);
    step(1'b1, 32'h00000000, 1'b1);
    lit("clear_beat", 1'b0, 32'h0, 1'b0, 4'b0000, 0, 0);
    step(1'b1, 32'h00000000, 1'b0);
    chk("after_clear_reload", 64'(out_valid), 64'(0));
    step(1'b1, 32'h00000000, 1'b0);
    chk("after_clear_out", 64'(out_valid), 64'(1));
    step(1'b0, '0, 1'b1);

`ifdef MCMP_HIT_CNT_EN
    // Five back-to-back matches saturate a 2-bit counter
    for (int k = 0; k < 6; k++) step(1'b1, 32'hC0A80101, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("cnt_sat", 64'(hit_cnt[0 +: CW]), 64'(3));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("cnt_after_clear", 64'(hit_cnt[0 +: CW]), 64'(3));
`endif

    // Random traffic over a small byte alphabet so hits are frequent
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        pat_load  = 1'b1;
        pat_sel   = IW'($urandom_range(0, NP - 1));
        pat_in    = rword();
        pat_en_in = ($urandom_range(0, 3) != 0);
      end
      step($urandom_range(0, 3) != 0, rword(), $urandom_range(0, 49) == 0);
      pat_load = 1'b0;
    end
    step(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
